rr_select_arbiter: RTL and testbench
====================================

// Module: rr_select_arbiter
//
// PURPOSE
//  Round-robin arbiter that picks one of N requesters and drives its binary
//  index into the registered 3-to-8 one-hot decoder stage directly downstream.
//  The index is held stable for the whole grant, so the decoder's one-hot
//  output is stable too. The grant ends on done, on the requester dropping its
//  request, or on a hold timeout. A timeout is flagged as an error.
//
// PARAMETERS
//  N_REQ     8   number of requesters; must equal 2**IDX_W
//  IDX_W     3   width of the sel index; matches the decoder select input
//  MAX_HOLD  15  maximum number of cycles sel_valid may stay high per grant (>=1)
//
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, synchronous, active-high
//  req          in   N_REQ  request lines, level-sensitive, bit i = requester i
//  done         in   1      current grantee finished; sampled only in GRANT
//  sel          out  IDX_W  granted index, registered; feeds decoder select
//  sel_valid    out  1      sel holds a live grant
//  busy         out  1      FSM is in GRANT (equals sel_valid)
//  timeout_err  out  1      one-cycle pulse when a grant is ended by timeout
//
// BEHAVIOUR
//  Reset (rst=1 at a rising edge):
//  - sel=0, sel_valid=0, busy=0, timeout_err=0.
//  - State IDLE, hold_cnt=0, last_ptr=N_REQ-1, so the first search starts at index 0.
//  - Reset has priority over everything. A reset during a grant aborts it
//    with no timeout_err.
//  FSM states: IDLE, GRANT.
//  IDLE:
//  - If req==0, stay in IDLE with outputs unchanged. sel keeps its last value.
//  - If req!=0, scan from (last_ptr+1) mod N_REQ upward, wrapping, and take
//    the first set bit.
//  - At that edge: sel=winner, sel_valid=1, hold_cnt=1, go to GRANT.
//  - Latency: req asserted before edge n gives sel_valid=1 after edge n.
//    The decoder output follows one edge later.
//  - done seen in IDLE is ignored.
//  GRANT: sel is held constant. Release conditions are checked each edge in
//  this priority order:
//  1. done=1 -> normal release
//  2. req[sel]=0 -> requester withdrew, normal release
//  3. hold_cnt==MAX_HOLD -> timeout release, timeout_err=1 for exactly one cycle
//  4. none of the above -> hold_cnt+=1, stay in GRANT
//  On any release edge:
//  - sel_valid=0, last_ptr=sel, go to IDLE. sel keeps its value.
//  - This guarantees at least one cycle of sel_valid=0 between grants, even
//    when other requests are pending.
//  Other rules:
//  - A timeout on the same edge as done or a dropped req is a normal release,
//    with no timeout_err.
//  - hold_cnt is $clog2(MAX_HOLD+1) bits wide and never wraps. It is cleared to 1 on each grant.
//  - Fairness: a requester that stays asserted is granted within N_REQ-1
//    intervening grants.
//  - Changes on req bits other than req[sel] during GRANT have no effect
//    until the next IDLE cycle.
//  - sel is always in range 0..N_REQ-1. No X on any output after reset.
//
// TESTING
//  1. Reset, then req=8'h01, done pulsed on the 3rd GRANT cycle:
//     -> sel=0, sel_valid=1 for 3 cycles, then 0 for 1 cycle.
//  2. req=8'hFF held, done pulsed on the 1st GRANT cycle of every grant:
//     -> sel sequence 0,1,...,7,0 with sel_valid alternating 1/0.
//  3. last_ptr=5, req=8'h21:
//     -> grant 0 first (wrap past 6,7), then 5; never 0 twice in a row.
//  4. req=8'h08 held, done never asserted:
//     -> sel=3 high for exactly 15 cycles, timeout_err=1 on the release edge
//     only, sel_valid=0 for 1 cycle, then sel=3 is re-granted.
//  5. Grant on 2, req[2] dropped mid-grant while req[6]=1:
//     -> release on that edge with no timeout_err, then sel=6 after one gap cycle.
//  6. rst asserted on the 4th GRANT cycle:
//     -> next edge gives sel=0, sel_valid=0, timeout_err=0.
//     After rst falls with req=8'h80 -> sel=7.
//     Also check done and timeout on the same edge -> timeout_err=0.

Source files
------------

// File: rtl/rr_select_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin select arbiter.
// master = arbiter side (drives the grant), slave = requester/decoder side.
interface rr_select_arbiter_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic [N_REQ-1:0] req;
    logic             done;
    logic [IDX_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic             timeout_err;

    modport master (
        input  req,
        input  done,
        output sel,
        output sel_valid,
        output busy,
        output timeout_err
    );

    modport slave (
        output req,
        output done,
        input  sel,
        input  sel_valid,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter holding one requester's index stable on sel for a whole grant.
// Latency: req before edge n -> sel/sel_valid after edge n; at least one idle cycle between grants.
// Backpressure: none; a grant ends on done, on a dropped req[sel], or on a MAX_HOLD timeout.
module rr_select_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_select_arbiter_if.master   bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d;
    logic             tmo_q, tmo_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [IDX_W-1:0] win;
    logic             win_found;

    // Search starts just after the last grantee; the index wraps naturally
    // because N_REQ is a power of two equal to 2**IDX_W.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last_q + IDX_W'(i);
            if (!win_found && bus.req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        tmo_d   = 1'b0;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    sel_d   = win;
                    vld_d   = 1'b1;
                    hold_d  = HW'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // done and a withdrawn request outrank the timeout, so a
                // coincident timeout is a clean release with no error pulse.
                if (bus.done || !bus.req[sel_q]) begin
                    vld_d   = 1'b0;
                    last_d  = sel_q;
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else if (hold_q == HW'(MAX_HOLD)) begin
                    vld_d   = 1'b0;
                    tmo_d   = 1'b1;
                    last_d  = sel_q;
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d  = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
            hold_q  <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sel_valid   = vld_q;
    assign bus.busy        = (state_q == ST_GRANT);
    assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed, table-driven bench for rr_select_arbiter: each vector is the input for one
// cycle and the outputs expected just after the following rising edge.
module tb_rr_select_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    rr_select_arbiter_if #(.N_REQ(8), .IDX_W(3)) bus ();

    rr_select_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [2:0] sel;
        logic       vld;
        logic       tmo;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [7:0] q, input logic d,
                                input logic [2:0] s, input logic v, input logic t,
                                input string nm);
        vec_t x;
        x.rst = r; x.req = q; x.done = d; x.sel = s; x.vld = v; x.tmo = t; x.name = nm;
        tbl.push_back(x);
    endfunction

    task automatic check1(input string nm, input logic [7:0] got, input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q, input logic d,
                        input logic [2:0] s, input logic v, input logic t, input string nm);
        rst      = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
        check1({nm, ".sel"},       {5'd0, bus.sel},   {5'd0, s});
        check1({nm, ".sel_valid"}, {7'd0, bus.sel_valid}, {7'd0, v});
        check1({nm, ".busy"},      {7'd0, bus.busy},  {7'd0, v});
        check1({nm, ".timeout"},   {7'd0, bus.timeout_err}, {7'd0, t});
    endtask

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;

        // Basic grant ended by done on the 3rd grant cycle, one gap, then re-grant.
        add(1, 8'h00, 0, 3'd0, 0, 0, "t1_reset");
        add(1, 8'h00, 0, 3'd0, 0, 0, "t1_reset2");
        add(0, 8'h01, 0, 3'd0, 1, 0, "t1_grant");
        add(0, 8'h01, 0, 3'd0, 1, 0, "t1_g2");
        add(0, 8'h01, 0, 3'd0, 1, 0, "t1_g3");
        add(0, 8'h01, 1, 3'd0, 0, 0, "t1_done");
        add(0, 8'h01, 0, 3'd0, 1, 0, "t1_regrant");
        add(0, 8'h00, 1, 3'd0, 0, 0, "t1_drop");
        add(0, 8'h00, 1, 3'd0, 0, 0, "t1_idle_done_ignored");

        // Full rotation with all requesters active.
        add(1, 8'h00, 0, 3'd0, 0, 0, "t2_reset");
        for (int k = 0; k < 9; k++) begin
            add(0, 8'hFF, 0, 3'(k % 8), 1, 0, $sformatf("t2_grant%0d", k));
            add(0, 8'hFF, 1, 3'(k % 8), 0, 0, $sformatf("t2_rel%0d", k));
        end

        // Wrap from last_ptr=5 past 6,7 to 0, then back to 5.
        add(0, 8'h20, 0, 3'd5, 1, 0, "t3_set5");
        add(0, 8'h20, 1, 3'd5, 0, 0, "t3_rel5");
        add(0, 8'h21, 0, 3'd0, 1, 0, "t3_wrap0");
        add(0, 8'h21, 1, 3'd0, 0, 0, "t3_rel0");
        add(0, 8'h21, 0, 3'd5, 1, 0, "t3_then5");
        add(0, 8'h21, 1, 3'd5, 0, 0, "t3_rel5b");
        add(0, 8'h21, 0, 3'd0, 1, 0, "t3_again0");
        add(0, 8'h21, 1, 3'd0, 0, 0, "t3_rel0b");
        add(0, 8'h00, 0, 3'd0, 0, 0, "t3_idle");

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].sel, tbl[i].vld, tbl[i].tmo, tbl[i].name);

        // Timeout: 15 grant cycles, one-cycle error pulse, then re-grant.
        step(0, 8'h08, 0, 3'd3, 1, 0, "t4_grant");
        for (int k = 0; k < 14; k++) step(0, 8'h08, 0, 3'd3, 1, 0, "t4_hold");
        step(0, 8'h08, 0, 3'd3, 0, 1, "t4_timeout");
        step(0, 8'h08, 0, 3'd3, 1, 0, "t4_regrant");
        step(0, 8'h00, 0, 3'd3, 0, 0, "t4_drop");

        // Withdrawn request mid-grant; other request changes ignored during grant.
        step(0, 8'h04, 0, 3'd2, 1, 0, "t5_grant2");
        step(0, 8'h44, 0, 3'd2, 1, 0, "t5_hold2");
        step(0, 8'h40, 0, 3'd2, 0, 0, "t5_withdraw");
        step(0, 8'h40, 0, 3'd6, 1, 0, "t5_grant6");
        step(0, 8'h00, 0, 3'd6, 0, 0, "t5_drop6");

        // Reset on 4th grant cycle aborts with no error; first search restarts at 0.
        step(0, 8'h01, 0, 3'd0, 1, 0, "t6_grant");
        step(0, 8'h01, 0, 3'd0, 1, 0, "t6_g2");
        step(0, 8'h01, 0, 3'd0, 1, 0, "t6_g3");
        step(1, 8'h01, 0, 3'd0, 0, 0, "t6_reset");
        step(0, 8'h80, 0, 3'd7, 1, 0, "t6_grant7");
        for (int k = 0; k < 14; k++) step(0, 8'h80, 0, 3'd7, 1, 0, "t6_hold");
        step(0, 8'h80, 1, 3'd7, 0, 0, "t6_done_at_timeout");
        step(0, 8'h80, 0, 3'd7, 1, 0, "t6_regrant7");
        for (int k = 0; k < 14; k++) step(0, 8'h80, 0, 3'd7, 1, 0, "t6_hold2");
        step(0, 8'h00, 0, 3'd7, 0, 0, "t6_drop_at_timeout");
        step(0, 8'h00, 0, 3'd7, 0, 0, "t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
